// File: rtl/input_conditioner.sv
// Multi-channel button/switch front end: synchroniser, debounce,
// level plus press/release strobes with optional auto-repeat.
module input_conditioner #(
  parameter int N               = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [N-1:0] raw_in_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] press_o,
  output logic [N-1:0] release_o,
  output logic         any_press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD)
                      ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  for (genvar c = 0; c < N; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic lvl_q, lvl_d;
    logic prs_q, prs_d;
    logic rel_q, rel_d;
    logic s, flip, rpt;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
      sync_d = SYNC_STAGES'({sync_q, raw_in_i[c]});
      flip   = (s != lvl_q) && (cnt_q == DB_LAST);
      cnt_d  = (s == lvl_q || flip) ? '0 : cnt_q + CW'(1);
      lvl_d  = flip ? s : lvl_q;
      prs_d  = (flip && s) || rpt;
      rel_d  = flip && !s;
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        sync_q <= '0;
        cnt_q  <= '0;
        lvl_q  <= 1'b0;
        prs_q  <= 1'b0;
        rel_q  <= 1'b0;
      end else begin
        sync_q <= sync_d;
        cnt_q  <= cnt_d;
        lvl_q  <= lvl_d;
        prs_q  <= prs_d;
        rel_q  <= rel_d;
      end
    end

    if (REPEAT_EN != 0) begin : g_rpt
      logic [RW-1:0] rcnt_q, rcnt_d;
      logic per_q, per_d;
      logic fire;

      // per_q selects the period once the first repeat has fired
      always_comb begin
        fire   = lvl_q && !flip
              && (rcnt_q == (per_q ? RP_LAST : RD_LAST));
        rcnt_d = rcnt_q + RW'(1);
        per_d  = per_q;
        if (!lvl_q || flip) begin
          rcnt_d = '0;
          per_d  = 1'b0;
        end else if (fire) begin
          rcnt_d = '0;
          per_d  = 1'b1;
        end
      end

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          rcnt_q <= '0;
          per_q  <= 1'b0;
        end else begin
          rcnt_q <= rcnt_d;
          per_q  <= per_d;
        end
      end

      assign rpt = fire;
    end else begin : g_norpt
      assign rpt = 1'b0;
    end

    assign level_o[c]   = lvl_q;
    assign press_o[c]   = prs_q;
    assign release_o[c] = rel_q;
  end

  assign any_press_o = |press_o;

endmodule
